// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-port signals of the memory port arbiter.
// slave is the arbiter's view; master is the view of the requesters and memory around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_ready;
  logic              i_resp_valid;
  logic [DATA_W-1:0] i_resp_data;
  logic              d_req_valid;
  logic              d_req_we;
  logic [3:0]        d_req_wmask;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_req_ready;
  logic              d_resp_valid;
  logic [DATA_W-1:0] d_resp_data;
  logic              m_req_valid;
  logic              m_req_we;
  logic [3:0]        m_req_wmask;
  logic [ADDR_W-1:0] m_req_addr;
  logic [DATA_W-1:0] m_req_wdata;
  logic              m_req_ready;
  logic              m_resp_valid;
  logic [DATA_W-1:0] m_resp_data;
  logic              err_resp;
  modport slave (
    input  i_req_valid, i_req_addr, d_req_valid, d_req_we, d_req_wmask, d_req_addr, d_req_wdata,
    input  m_req_ready, m_resp_valid, m_resp_data,
    output i_req_ready, i_resp_valid, i_resp_data, d_req_ready, d_resp_valid, d_resp_data,
    output m_req_valid, m_req_we, m_req_wmask, m_req_addr, m_req_wdata, err_resp
  );
  modport master (
    output i_req_valid, i_req_addr, d_req_valid, d_req_we, d_req_wmask, d_req_addr, d_req_wdata,
    output m_req_ready, m_resp_valid, m_resp_data,
    input  i_req_ready, i_resp_valid, i_resp_data, d_req_ready, d_resp_valid, d_resp_data,
    input  m_req_valid, m_req_we, m_req_wmask, m_req_addr, m_req_wdata, err_resp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and load/store (D), D-priority with I anti-starvation.
// Define ARB_PERF_CNT_EN to add the i_stall_cnt/d_stall_cnt stall counters.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_OUT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]        i_stall_cnt,
  output logic [31:0]        d_stall_cnt
`endif
);
  localparam int PW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {ARB, HOLD_I, HOLD_D} state_t;
  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [MAX_OUT-1:0] own_q, own_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          sel_i, sel_d, full, empty, accept, push, pop, head;
  always_comb begin
    full             = cnt_q == CW'(MAX_OUT);
    empty            = cnt_q == '0;
    sel_d            = state_q == HOLD_D || (state_q == ARB && bus.d_req_valid &&
                       !(starve_q == SW'(STARVE_LIMIT) && bus.i_req_valid));
    sel_i            = state_q == HOLD_I || (state_q == ARB && !sel_d && bus.i_req_valid);
    bus.m_req_valid  = rst_n && !full && (sel_d ? bus.d_req_valid : sel_i && bus.i_req_valid);
    accept           = bus.m_req_valid && bus.m_req_ready;
    bus.m_req_we     = sel_d && bus.d_req_we;
    bus.m_req_wmask  = sel_d ? bus.d_req_wmask : 4'h0;
    bus.m_req_addr   = sel_d ? bus.d_req_addr : sel_i ? bus.i_req_addr : ADDR_W'(0);
    bus.m_req_wdata  = sel_d ? bus.d_req_wdata : DATA_W'(0);
    bus.i_req_ready  = sel_i && accept;
    bus.d_req_ready  = sel_d && accept;
    push             = accept && !bus.m_req_we;
    pop              = bus.m_resp_valid && !empty;
    head             = own_q[rd_q];
    bus.i_resp_valid = rst_n && pop && !head;
    bus.d_resp_valid = rst_n && pop && head;
    bus.i_resp_data  = bus.m_resp_data;
    bus.d_resp_data  = bus.m_resp_data;
    bus.err_resp     = err_q;
    state_d          = accept ? ARB : (state_q == ARB && bus.m_req_valid) ? (sel_d ? HOLD_D : HOLD_I) : state_q;
    starve_d         = (accept && sel_d && bus.i_req_valid) ?
                       (starve_q == SW'(STARVE_LIMIT) ? starve_q : starve_q + 1'b1) :
                       ((accept && sel_i) || !bus.i_req_valid) ? '0 : starve_q;
    own_d            = own_q;
    if (push) own_d[wr_q] = sel_d;
    wr_d             = push ? (MAX_OUT == 1 ? '0 : wr_q + 1'b1) : wr_q;
    rd_d             = pop ? (MAX_OUT == 1 ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d            = cnt_q + CW'(push) - CW'(pop);
    // a response with nothing outstanding is dropped and flagged until reset
    err_d            = err_q || (bus.m_resp_valid && empty);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      starve_q <= '0;
      own_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      own_q    <= own_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
`ifdef ARB_PERF_CNT_EN
  logic [31:0] i_stall_q, i_stall_d, d_stall_q, d_stall_d;
  always_comb begin
    i_stall_d = i_stall_q + 32'(bus.i_req_valid && !bus.i_req_ready);
    d_stall_d = d_stall_q + 32'(bus.d_req_valid && !bus.d_req_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_stall_q <= '0;
      d_stall_q <= '0;
    end else begin
      i_stall_q <= i_stall_d;
      d_stall_q <= d_stall_d;
    end
  end
  assign i_stall_cnt = i_stall_q;
  assign d_stall_cnt = d_stall_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios then random traffic, checked against an owner-queue reference model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus ();
`ifdef ARB_PERF_CNT_EN
  logic [31:0] i_stall_cnt, d_stall_cnt;
  mem_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt));
`else
  mem_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif
  int n_chk = 0, n_pass = 0;
  int starve = 0, hold = 0;
  int q[$];
  bit err = 1'b0;
  int i_stall = 0, d_stall = 0;
  logic [1:0] last_rdy;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask
  task automatic idle();
    bus.i_req_valid = 0; bus.i_req_addr = '0;
    bus.d_req_valid = 0; bus.d_req_we = 0; bus.d_req_wmask = '0; bus.d_req_addr = '0; bus.d_req_wdata = '0;
    bus.m_req_ready = 0; bus.m_resp_valid = 0; bus.m_resp_data = '0;
  endtask
  task automatic model_clear();
    starve = 0; hold = 0; q.delete(); err = 0; i_stall = 0; d_stall = 0;
  endtask
  // One clock: inputs already driven just after the edge; check mid-cycle, then update the model.
  task automatic cyc();
    int g;
    bit mv, acc, iv, dv, resp;
    #4;
    iv = bus.i_req_valid; dv = bus.d_req_valid;
    g = hold != 0 ? hold : (dv && !(starve == 4 && iv)) ? 2 : iv ? 1 : 0;
    mv = g != 0 && q.size() < 2;
    acc = mv && bus.m_req_ready;
    resp = bus.m_resp_valid;
    chk("m_req_valid", bus.m_req_valid, mv);
    if (mv) begin
      chk("m_req_addr", bus.m_req_addr, g == 2 ? bus.d_req_addr : bus.i_req_addr);
      chk("m_req_we", bus.m_req_we, g == 2 && bus.d_req_we);
      chk("m_req_wmask", bus.m_req_wmask, g == 2 ? bus.d_req_wmask : 4'h0);
      if (g == 2) chk("m_req_wdata", bus.m_req_wdata, bus.d_req_wdata);
    end
    chk("i_req_ready", bus.i_req_ready, acc && g == 1);
    chk("d_req_ready", bus.d_req_ready, acc && g == 2);
    if (resp && q.size() > 0) begin
      chk("i_resp_valid", bus.i_resp_valid, q[0] == 1);
      chk("d_resp_valid", bus.d_resp_valid, q[0] == 2);
      if (q[0] == 1) chk("i_resp_data", bus.i_resp_data, bus.m_resp_data);
      else chk("d_resp_data", bus.d_resp_data, bus.m_resp_data);
    end else
      chk("resp_valid_idle", {bus.i_resp_valid, bus.d_resp_valid}, 2'b00);
    chk("err_resp", bus.err_resp, err);
`ifdef ARB_PERF_CNT_EN
    chk("i_stall_cnt", i_stall_cnt, i_stall);
    chk("d_stall_cnt", d_stall_cnt, d_stall);
`endif
    last_rdy = {bus.i_req_ready, bus.d_req_ready};
    i_stall += int'(iv && !(acc && g == 1));
    d_stall += int'(dv && !(acc && g == 2));
    if (resp) begin
      if (q.size() > 0) void'(q.pop_front());
      else err = 1;
    end
    if (acc && !(g == 2 && bus.d_req_we)) q.push_back(g);
    if (acc && g == 2 && iv) starve = starve < 4 ? starve + 1 : 4;
    else if ((acc && g == 1) || !iv) starve = 0;
    hold = acc ? 0 : mv ? g : hold;
    @(posedge clk); #1;
  endtask
  task automatic check_in_reset();
    chk("rst_m_req_valid", bus.m_req_valid, 1'b0);
    chk("rst_req_ready", {bus.i_req_ready, bus.d_req_ready}, 2'b00);
    chk("rst_resp_valid", {bus.i_resp_valid, bus.d_resp_valid}, 2'b00);
    chk("rst_err_resp", bus.err_resp, 1'b0);
`ifdef ARB_PERF_CNT_EN
    chk("rst_stall_cnt", {i_stall_cnt, d_stall_cnt}, 64'h0);
`endif
  endtask
  task automatic do_reset();
    rst_n = 0;
    bus.i_req_valid = 1; bus.d_req_valid = 1; bus.m_req_ready = 1; bus.m_resp_valid = 1;
    #2;
    check_in_reset();
    @(posedge clk); #1;
    idle(); rst_n = 1; model_clear();
  endtask
  task automatic drain();
    idle();
    while (q.size() > 0) begin
      bus.m_resp_valid = 1; bus.m_resp_data = $urandom;
      cyc();
    end
    bus.m_resp_valid = 0;
  endtask
  initial begin
    idle();
    do_reset();
    // single fetch with a one-cycle memory
    bus.i_req_valid = 1; bus.i_req_addr = 32'h1000; bus.m_req_ready = 1;
    cyc();
    chk("t1_i_ready", last_rdy, 2'b10);
    bus.i_req_valid = 0; bus.m_resp_valid = 1; bus.m_resp_data = 32'hDEADBEEF;
    cyc();
    bus.m_resp_valid = 0;
    // both requesting every cycle: D,D,D,D,I repeating
    for (int k = 0; k < 10; k++) begin
      bus.i_req_valid = 1; bus.i_req_addr = 32'h100 + 32'(k * 4);
      bus.d_req_valid = 1; bus.d_req_we = 0; bus.d_req_addr = $urandom;
      bus.m_req_ready = 1; bus.m_resp_valid = q.size() > 0; bus.m_resp_data = $urandom;
      cyc();
      chk("t2_grant", last_rdy, k % 5 == 4 ? 2'b10 : 2'b01);
    end
    drain();
    // store held off by memory for 3 cycles, fetch arrives meanwhile
    bus.d_req_valid = 1; bus.d_req_we = 1; bus.d_req_addr = 32'h2000; bus.d_req_wdata = 32'h55AA; bus.d_req_wmask = 4'hF;
    cyc();
    bus.i_req_valid = 1; bus.i_req_addr = 32'h3000;
    cyc();
    cyc();
    chk("t3_held_addr", bus.m_req_addr, 32'h2000);
    bus.m_req_ready = 1;
    cyc();
    chk("t3_d_accept", last_rdy, 2'b01);
    bus.d_req_valid = 0;
    cyc();
    chk("t3_i_after", last_rdy, 2'b10);
    drain();
    // owner FIFO fills, issue resumes the cycle after a pop
    bus.m_req_ready = 1; bus.i_req_valid = 1; bus.i_req_addr = 32'h4000;
    cyc();
    bus.i_req_valid = 0; bus.d_req_valid = 1; bus.d_req_we = 0; bus.d_req_addr = 32'h5000;
    cyc();
    bus.d_req_valid = 0; bus.i_req_valid = 1; bus.i_req_addr = 32'h4004;
    cyc();
    cyc();
    bus.m_resp_valid = 1; bus.m_resp_data = 32'h111;
    cyc();
    chk("t4_no_bypass", last_rdy, 2'b00);
    bus.m_resp_valid = 0;
    cyc();
    chk("t4_resume", last_rdy, 2'b10);
    bus.i_req_valid = 0;
    bus.m_resp_valid = 1; bus.m_resp_data = 32'h222;
    cyc();
    bus.m_resp_data = 32'h333;
    cyc();
    drain();
    // stray response
    bus.m_resp_valid = 1; bus.m_resp_data = 32'hBAD;
    cyc();
    bus.m_resp_valid = 0;
    for (int k = 0; k < 3; k++) cyc();
    chk("t5_err_sticky", bus.err_resp, 1'b1);
    // asynchronous reset while D is held with a read outstanding
    bus.m_req_ready = 1; bus.i_req_valid = 1; bus.i_req_addr = 32'h6000;
    cyc();
    bus.i_req_valid = 0; bus.d_req_valid = 1; bus.d_req_we = 0; bus.d_req_addr = 32'h7000; bus.m_req_ready = 0;
    cyc();
    cyc();
    #2;
    bus.m_req_ready = 1; bus.m_resp_valid = 1; bus.i_req_valid = 1;
    rst_n = 0;
    #1;
    check_in_reset();
    @(posedge clk); #1;
    idle(); rst_n = 1; model_clear();
    cyc();
    bus.m_resp_valid = 1;
    cyc();
    bus.m_resp_valid = 0;
    cyc();
    chk("t6_stray_err", bus.err_resp, 1'b1);
    do_reset();
    // random traffic
    for (int k = 0; k < 400; k++) begin
      if (hold != 2) begin
        bus.d_req_valid = 1'($urandom_range(1));
        bus.d_req_we = $urandom_range(2) == 0;
        bus.d_req_wmask = 4'($urandom);
        bus.d_req_addr = $urandom;
        bus.d_req_wdata = $urandom;
      end
      if (hold != 1) begin
        bus.i_req_valid = 1'($urandom_range(1));
        bus.i_req_addr = $urandom;
      end
      bus.m_req_ready = $urandom_range(3) != 0;
      bus.m_resp_valid = q.size() > 0 && $urandom_range(1) == 1;
      bus.m_resp_data = $urandom;
      cyc();
    end
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
